// File: rtl/pspin_pkt_tx_merge.sv
// Frame-atomic merge of host NIC TX and PsPIN TX AXI-Stream sources into the NIC TX stream,
// with MTU beat-limit truncation and saturating frame statistics.
module pspin_pkt_tx_merge #(
  parameter int unsigned UMATCH_MTU            = 1500,
  parameter int unsigned AXIS_IF_DATA_WIDTH    = 512,
  parameter int unsigned AXIS_IF_KEEP_WIDTH    = AXIS_IF_DATA_WIDTH / 8,
  parameter int unsigned AXIS_IF_TX_ID_WIDTH   = 1,
  parameter int unsigned AXIS_IF_TX_DEST_WIDTH = 8,
  parameter int unsigned AXIS_IF_TX_USER_WIDTH = 17,
  parameter int unsigned STAT_WIDTH            = 32
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_nic_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_nic_tx_tkeep,
  input  logic                             s_axis_nic_tx_tvalid,
  output logic                             s_axis_nic_tx_tready,
  input  logic                             s_axis_nic_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_nic_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_nic_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_nic_tx_tuser,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_pspin_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_pspin_tx_tkeep,
  input  logic                             s_axis_pspin_tx_tvalid,
  output logic                             s_axis_pspin_tx_tready,
  input  logic                             s_axis_pspin_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_pspin_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_pspin_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_pspin_tx_tuser,

  output logic [AXIS_IF_DATA_WIDTH-1:0]    m_axis_nic_tx_tdata,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]    m_axis_nic_tx_tkeep,
  output logic                             m_axis_nic_tx_tvalid,
  input  logic                             m_axis_nic_tx_tready,
  output logic                             m_axis_nic_tx_tlast,
  output logic [AXIS_IF_TX_ID_WIDTH-1:0]   m_axis_nic_tx_tid,
  output logic [AXIS_IF_TX_DEST_WIDTH-1:0] m_axis_nic_tx_tdest,
  output logic [AXIS_IF_TX_USER_WIDTH-1:0] m_axis_nic_tx_tuser,

  input  logic                             arb_mode,
  output logic [STAT_WIDTH-1:0]            stat_nic_frames,
  output logic [STAT_WIDTH-1:0]            stat_pspin_frames,
  output logic [STAT_WIDTH-1:0]            stat_trunc_frames
);

  localparam int unsigned MAX_BEATS = (UMATCH_MTU * 8 + AXIS_IF_DATA_WIDTH - 1) / AXIS_IF_DATA_WIDTH;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, FWD_NIC, FWD_PSPIN, DROP} state_t;

  state_t           state, state_nxt;
  logic             grant_pspin, grant_pspin_nxt;
  logic             rr_pspin;      // source preferred on the next round-robin tie
  logic             grant_evt;
  logic [CNT_W-1:0] beat_cnt;

  logic                             sel_pspin;
  logic                             fwd;
  logic                             out_ready;
  logic                             in_tvalid;
  logic                             in_tlast;
  logic [AXIS_IF_DATA_WIDTH-1:0]    in_tdata;
  logic [AXIS_IF_KEEP_WIDTH-1:0]    in_tkeep;
  logic [AXIS_IF_TX_ID_WIDTH-1:0]   in_tid;
  logic [AXIS_IF_TX_DEST_WIDTH-1:0] in_tdest;
  logic [AXIS_IF_TX_USER_WIDTH-1:0] in_tuser;
  logic                             accept;
  logic                             load;
  logic                             trunc;

  // Source mux: DROP keeps draining whichever source was granted
  always_comb begin
    sel_pspin = (state == FWD_PSPIN) || ((state == DROP) && grant_pspin);
    fwd       = (state == FWD_NIC) || (state == FWD_PSPIN);
    out_ready = !m_axis_nic_tx_tvalid || m_axis_nic_tx_tready;
    if (sel_pspin) begin
      in_tvalid = s_axis_pspin_tx_tvalid;
      in_tlast  = s_axis_pspin_tx_tlast;
      in_tdata  = s_axis_pspin_tx_tdata;
      in_tkeep  = s_axis_pspin_tx_tkeep;
      in_tid    = s_axis_pspin_tx_tid;
      in_tdest  = s_axis_pspin_tx_tdest;
      in_tuser  = s_axis_pspin_tx_tuser;
    end else begin
      in_tvalid = s_axis_nic_tx_tvalid;
      in_tlast  = s_axis_nic_tx_tlast;
      in_tdata  = s_axis_nic_tx_tdata;
      in_tkeep  = s_axis_nic_tx_tkeep;
      in_tid    = s_axis_nic_tx_tid;
      in_tdest  = s_axis_nic_tx_tdest;
      in_tuser  = s_axis_nic_tx_tuser;
    end
  end

  // Next-state, grant and ready logic
  always_comb begin
    state_nxt              = state;
    grant_pspin_nxt        = grant_pspin;
    grant_evt              = 1'b0;
    s_axis_nic_tx_tready   = 1'b0;
    s_axis_pspin_tx_tready = 1'b0;
    accept                 = 1'b0;
    load                   = 1'b0;
    trunc                  = 1'b0;

    unique case (state)
      IDLE: begin
        if (s_axis_nic_tx_tvalid || s_axis_pspin_tx_tvalid) begin
          grant_evt = 1'b1;
          if (arb_mode) begin
            grant_pspin_nxt = s_axis_pspin_tx_tvalid;
          end else begin
            grant_pspin_nxt = s_axis_pspin_tx_tvalid && (!s_axis_nic_tx_tvalid || rr_pspin);
          end
          state_nxt = grant_pspin_nxt ? FWD_PSPIN : FWD_NIC;
        end
      end
      FWD_NIC, FWD_PSPIN: begin
        s_axis_nic_tx_tready   = (state == FWD_NIC) && out_ready;
        s_axis_pspin_tx_tready = (state == FWD_PSPIN) && out_ready;
        accept = in_tvalid && out_ready;
        load   = accept;
        trunc  = accept && !in_tlast && (beat_cnt == CNT_W'(MAX_BEATS - 1));
        if (accept && in_tlast) begin
          state_nxt = IDLE;
        end else if (trunc) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        s_axis_nic_tx_tready   = !grant_pspin;
        s_axis_pspin_tx_tready = grant_pspin;
        accept = in_tvalid;
        if (accept && in_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_pspin <= 1'b0;
      rr_pspin    <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_pspin <= grant_pspin_nxt;
      if (grant_evt) begin
        rr_pspin <= !grant_pspin_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= (in_tlast || trunc) ? '0 : beat_cnt + CNT_W'(1);
    end else if (!fwd) begin
      beat_cnt <= '0;
    end
  end

  // Single output register; truncated beat is closed and marked bad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_nic_tx_tvalid <= 1'b0;
      m_axis_nic_tx_tlast  <= 1'b0;
      m_axis_nic_tx_tdata  <= '0;
      m_axis_nic_tx_tkeep  <= '0;
      m_axis_nic_tx_tid    <= '0;
      m_axis_nic_tx_tdest  <= '0;
      m_axis_nic_tx_tuser  <= '0;
    end else if (load) begin
      m_axis_nic_tx_tvalid   <= 1'b1;
      m_axis_nic_tx_tlast    <= in_tlast || trunc;
      m_axis_nic_tx_tdata    <= in_tdata;
      m_axis_nic_tx_tkeep    <= in_tkeep;
      m_axis_nic_tx_tid      <= in_tid;
      m_axis_nic_tx_tdest    <= in_tdest;
      m_axis_nic_tx_tuser    <= in_tuser;
      m_axis_nic_tx_tuser[0] <= in_tuser[0] || trunc;
    end else if (m_axis_nic_tx_tready) begin
      m_axis_nic_tx_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_nic_frames   <= '0;
      stat_pspin_frames <= '0;
      stat_trunc_frames <= '0;
    end else begin
      if (load && in_tlast && !sel_pspin && (stat_nic_frames != '1)) begin
        stat_nic_frames <= stat_nic_frames + STAT_WIDTH'(1);
      end
      if (load && in_tlast && sel_pspin && (stat_pspin_frames != '1)) begin
        stat_pspin_frames <= stat_pspin_frames + STAT_WIDTH'(1);
      end
      if (trunc && (stat_trunc_frames != '1)) begin
        stat_trunc_frames <= stat_trunc_frames + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pspin_pkt_tx_merge.sv
// Directed bench for pspin_pkt_tx_merge: a table of single-frame vectors plus hand-written
// arbitration, back-pressure and mid-frame reset sequences.
module tb_pspin_pkt_tx_merge;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] nic_tdata, psp_tdata, m_tdata;
  logic [63:0]  nic_tkeep, psp_tkeep, m_tkeep;
  logic         nic_tvalid, psp_tvalid, m_tvalid;
  logic         nic_tready, psp_tready, m_tready;
  logic         nic_tlast, psp_tlast, m_tlast;
  logic [0:0]   nic_tid, psp_tid, m_tid;
  logic [7:0]   nic_tdest, psp_tdest, m_tdest;
  logic [16:0]  nic_tuser, psp_tuser, m_tuser;
  logic         arb_mode;
  logic [31:0]  stat_nic, stat_psp, stat_trunc;

  pspin_pkt_tx_merge dut (
    .clk(clk), .rst(rst),
    .s_axis_nic_tx_tdata(nic_tdata), .s_axis_nic_tx_tkeep(nic_tkeep),
    .s_axis_nic_tx_tvalid(nic_tvalid), .s_axis_nic_tx_tready(nic_tready),
    .s_axis_nic_tx_tlast(nic_tlast), .s_axis_nic_tx_tid(nic_tid),
    .s_axis_nic_tx_tdest(nic_tdest), .s_axis_nic_tx_tuser(nic_tuser),
    .s_axis_pspin_tx_tdata(psp_tdata), .s_axis_pspin_tx_tkeep(psp_tkeep),
    .s_axis_pspin_tx_tvalid(psp_tvalid), .s_axis_pspin_tx_tready(psp_tready),
    .s_axis_pspin_tx_tlast(psp_tlast), .s_axis_pspin_tx_tid(psp_tid),
    .s_axis_pspin_tx_tdest(psp_tdest), .s_axis_pspin_tx_tuser(psp_tuser),
    .m_axis_nic_tx_tdata(m_tdata), .m_axis_nic_tx_tkeep(m_tkeep),
    .m_axis_nic_tx_tvalid(m_tvalid), .m_axis_nic_tx_tready(m_tready),
    .m_axis_nic_tx_tlast(m_tlast), .m_axis_nic_tx_tid(m_tid),
    .m_axis_nic_tx_tdest(m_tdest), .m_axis_nic_tx_tuser(m_tuser),
    .arb_mode(arb_mode),
    .stat_nic_frames(stat_nic), .stat_pspin_frames(stat_psp), .stat_trunc_frames(stat_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tag;
    logic        last;
    logic [16:0] user;
    logic [63:0] keep;
    logic        id;
  } beat_t;

  typedef struct {
    bit src;
    int len;
    int exp_beats;
    bit exp_bad;
    int exp_nic;
    int exp_psp;
    int exp_trunc;
  } vec_t;

  localparam logic [63:0] KEEP_TAIL = 64'h0000_0000_0000_FFFF;

  beat_t nic_q[$], psp_q[$], out_q[$];
  int    out_cyc[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    stall_mode = 0;
  bit    prev_stall = 0;
  bit    nic_rdy_any, psp_rdy_any, nic_rdy_while_psp;
  logic [602:0] snap_prev, snap_cur;
  vec_t  vecs[7];
  logic [31:0] exp_tags[8];
  logic        exp_ids[8];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mk_tag(input bit src, input int fid, input int b);
    return {8'(src), 8'(fid), 16'(b)};
  endfunction

  task automatic push_frame(input bit src, input int fid, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.tag  = mk_tag(src, fid, i);
      b.last = (i == len - 1);
      b.user = {16'(fid), 1'b0};
      b.keep = (i == len - 1) ? KEEP_TAIL : '1;
      b.id   = src;
      if (src) psp_q.push_back(b);
      else     nic_q.push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, edge follows
  task automatic cycle();
    beat_t o;
    bit n_acc, p_acc;
    @(negedge clk);
    if (nic_q.size() > 0) begin
      nic_tvalid = 1'b1; nic_tdata = 512'(nic_q[0].tag); nic_tkeep = nic_q[0].keep;
      nic_tlast = nic_q[0].last; nic_tuser = nic_q[0].user; nic_tid = 1'b0;
      nic_tdest = nic_q[0].tag[23:16];
    end else begin
      nic_tvalid = 1'b0; nic_tlast = 1'b0;
    end
    if (psp_q.size() > 0) begin
      psp_tvalid = 1'b1; psp_tdata = 512'(psp_q[0].tag); psp_tkeep = psp_q[0].keep;
      psp_tlast = psp_q[0].last; psp_tuser = psp_q[0].user; psp_tid = 1'b1;
      psp_tdest = psp_q[0].tag[23:16];
    end else begin
      psp_tvalid = 1'b0; psp_tlast = 1'b0;
    end
    m_tready = stall_mode ? ~m_tready : 1'b1;
    #1;
    n_acc = nic_tvalid && nic_tready;
    p_acc = psp_tvalid && psp_tready;
    if (nic_tready) nic_rdy_any = 1;
    if (psp_tready) psp_rdy_any = 1;
    if (nic_tready && psp_tvalid) nic_rdy_while_psp = 1;
    snap_cur = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    if (prev_stall) begin
      chk("stall_valid_hold", 64'(m_tvalid), 64'd1);
      chk("stall_fields_hold", 64'(snap_cur == snap_prev), 64'd1);
    end
    if (m_tvalid && m_tready) begin
      o.tag = m_tdata[31:0]; o.last = m_tlast; o.user = m_tuser; o.keep = m_tkeep; o.id = m_tid[0];
      out_q.push_back(o);
      out_cyc.push_back(cyc);
    end
    prev_stall = m_tvalid && !m_tready;
    snap_prev  = snap_cur;
    cyc++;
    if (n_acc) void'(nic_q.pop_front());
    if (p_acc) void'(psp_q.pop_front());
  endtask

  task automatic clear_run();
    out_q.delete(); out_cyc.delete(); cyc = 0;
    nic_rdy_any = 0; psp_rdy_any = 0; nic_rdy_while_psp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    nic_q.delete(); psp_q.delete();
    nic_tvalid = 1'b0; psp_tvalid = 1'b0; prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int n);
    chk({name, "_count"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      chk({name, "_tag"}, 64'(out_q[i].tag), 64'(exp_tags[i]));
      chk({name, "_tid"}, 64'(out_q[i].id), 64'(exp_ids[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arb_mode = 1'b0; m_tready = 1'b1;
    nic_tvalid = 0; psp_tvalid = 0; nic_tlast = 0; psp_tlast = 0;
    nic_tdata = '0; psp_tdata = '0; nic_tkeep = '0; psp_tkeep = '0;
    nic_tid = '0; psp_tid = '0; nic_tdest = '0; psp_tdest = '0; nic_tuser = '0; psp_tuser = '0;
    #3;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata != '0), 64'd0);
    chk("rst_m_fields", 64'({m_tkeep, m_tid, m_tdest, m_tuser} != '0), 64'd0);
    chk("rst_tready", 64'({nic_tready, psp_tready}), 64'd0);
    chk("rst_stats", 64'({stat_nic, stat_psp, stat_trunc} != '0), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // src, len, out beats, bad, cumulative nic/pspin/trunc stats
    vecs[0] = '{1'b1, 30, 24, 1'b1, 0, 0, 1};
    vecs[1] = '{1'b1, 24, 24, 1'b0, 0, 1, 1};
    vecs[2] = '{1'b0,  3,  3, 1'b0, 1, 1, 1};
    vecs[3] = '{1'b1,  1,  1, 1'b0, 1, 2, 1};
    vecs[4] = '{1'b0, 24, 24, 1'b0, 2, 2, 1};
    vecs[5] = '{1'b0, 25, 24, 1'b1, 2, 2, 2};
    vecs[6] = '{1'b0,  1,  1, 1'b0, 3, 2, 2};

    for (int v = 0; v < 7; v++) begin
      clear_run();
      push_frame(vecs[v].src, v, vecs[v].len);
      repeat (vecs[v].len + 6) cycle();
      chk("vec_src_drained", 64'(vecs[v].src ? psp_q.size() : nic_q.size()), 64'd0);
      chk("vec_beats", 64'(out_q.size()), 64'(vecs[v].exp_beats));
      for (int b = 0; b < vecs[v].exp_beats && b < out_q.size(); b++) begin
        chk("vec_tag", 64'(out_q[b].tag), 64'(mk_tag(vecs[v].src, v, b)));
        chk("vec_last", 64'(out_q[b].last), 64'(b == vecs[v].exp_beats - 1));
        chk("vec_user", 64'(out_q[b].user),
            64'({16'(v), vecs[v].exp_bad && (b == vecs[v].exp_beats - 1)}));
        chk("vec_keep", out_q[b].keep, (b == vecs[v].len - 1) ? KEEP_TAIL : 64'hFFFF_FFFF_FFFF_FFFF);
        chk("vec_tid", 64'(out_q[b].id), 64'(vecs[v].src));
      end
      chk("vec_other_tready", 64'(vecs[v].src ? nic_rdy_any : psp_rdy_any), 64'd0);
      chk("vec_stat_nic", 64'(stat_nic), 64'(vecs[v].exp_nic));
      chk("vec_stat_pspin", 64'(stat_psp), 64'(vecs[v].exp_psp));
      chk("vec_stat_trunc", 64'(stat_trunc), 64'(vecs[v].exp_trunc));
    end

    // Round robin with both sources continuously valid
    do_reset();
    clear_run();
    arb_mode = 1'b0;
    push_frame(0, 10, 2); push_frame(0, 11, 2);
    push_frame(1, 20, 2); push_frame(1, 21, 2);
    repeat (16) cycle();
    exp_tags = '{mk_tag(0,10,0), mk_tag(0,10,1), mk_tag(1,20,0), mk_tag(1,20,1),
                 mk_tag(0,11,0), mk_tag(0,11,1), mk_tag(1,21,0), mk_tag(1,21,1)};
    exp_ids  = '{0, 0, 1, 1, 0, 0, 1, 1};
    chk_seq("rr", 8);
    for (int i = 0; i < 7 && i + 1 < out_cyc.size(); i++)
      chk("rr_spacing", 64'(out_cyc[i+1] - out_cyc[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
    chk("rr_stat_nic", 64'(stat_nic), 64'd2);
    chk("rr_stat_pspin", 64'(stat_psp), 64'd2);

    // Strict PsPIN priority
    clear_run();
    arb_mode = 1'b1;
    push_frame(0, 10, 2); push_frame(0, 11, 2);
    push_frame(1, 20, 2); push_frame(1, 21, 2);
    repeat (16) cycle();
    exp_tags = '{mk_tag(1,20,0), mk_tag(1,20,1), mk_tag(1,21,0), mk_tag(1,21,1),
                 mk_tag(0,10,0), mk_tag(0,10,1), mk_tag(0,11,0), mk_tag(0,11,1)};
    exp_ids  = '{1, 1, 1, 1, 0, 0, 0, 0};
    chk_seq("strict", 8);
    chk("strict_nic_rdy_while_psp", 64'(nic_rdy_while_psp), 64'd0);
    arb_mode = 1'b0;

    // Output back-pressure toggling every cycle
    clear_run();
    stall_mode = 1;
    push_frame(0, 30, 4);
    repeat (20) cycle();
    stall_mode = 0;
    exp_tags = '{mk_tag(0,30,0), mk_tag(0,30,1), mk_tag(0,30,2), mk_tag(0,30,3), 0, 0, 0, 0};
    exp_ids  = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("stall", 4);
    if (out_q.size() == 4) chk("stall_last", 64'({out_q[0].last, out_q[1].last, out_q[2].last, out_q[3].last}), 64'b0001);

    // Reset asserted with beat 2 of a 5-beat frame in the output register
    clear_run();
    push_frame(0, 40, 5);
    repeat (3) cycle();
    chk("midrst_accepted", 64'(nic_q.size()), 64'd3);
    @(negedge clk);
    chk("midrst_pre_valid", 64'(m_tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_stats", 64'({stat_nic, stat_psp, stat_trunc} != '0), 64'd0);
    chk("midrst_tready", 64'({nic_tready, psp_tready}), 64'd0);
    nic_q.delete(); nic_tvalid = 1'b0; prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    clear_run();
    push_frame(0, 41, 2);
    repeat (8) cycle();
    exp_tags = '{mk_tag(0,41,0), mk_tag(0,41,1), 0, 0, 0, 0, 0, 0};
    exp_ids  = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("postrst", 2);
    chk("postrst_stat_nic", 64'(stat_nic), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
